mc_cu: RTL

MC_CU -- requirements
Module: mc_cu

---
 rtl/mc_cu.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/mc_cu.sv
// mc_cu: multicycle control unit for a MIPS-subset datapath.
// Sequences IF/ID/EXE/MEM/WB, decodes op/func into datapath controls,
// counts retired instructions and traps undecoded instructions.
module mc_cu #(
  parameter int unsigned CNT_W        = 16,
  parameter bit          TRAP_ILLEGAL = 1'b1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [5:0]       op,
  input  logic [5:0]       func,
  input  logic             z,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             iord,
  output logic             wmem,
  output logic             wir,
  output logic             wpc,
  output logic             wreg,
  output logic             regrt,
  output logic             m2reg,
  output logic             jal,
  output logic             shift,
  output logic             sext,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [3:0]       aluc,
  output logic [1:0]       pcsource,
  output logic [2:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_ERR = 3'd7
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  state_t state_q, next_state;

  logic is_add, is_sub, is_and, is_or, is_xor, is_sll, is_srl, is_sra, is_jr;
  logic is_addi, is_andi, is_ori, is_xori, is_lui;
  logic is_lw, is_sw, is_beq, is_bne, is_j, is_jal;
  logic r_alu, i_alu, is_shift, decoded;
  logic [3:0] alu_code;

  logic mem_req_c, wmem_c, wir_c, wpc_c, wreg_c;

  // Instruction decode from op/func fields
  always_comb begin
    is_add  = (op == 6'b000000) && (func == 6'b100000);
    is_sub  = (op == 6'b000000) && (func == 6'b100010);
    is_and  = (op == 6'b000000) && (func == 6'b100100);
    is_or   = (op == 6'b000000) && (func == 6'b100101);
    is_xor  = (op == 6'b000000) && (func == 6'b100110);
    is_sll  = (op == 6'b000000) && (func == 6'b000000);
    is_srl  = (op == 6'b000000) && (func == 6'b000010);
    is_sra  = (op == 6'b000000) && (func == 6'b000011);
    is_jr   = (op == 6'b000000) && (func == 6'b001000);
    is_addi = (op == 6'b001000);
    is_andi = (op == 6'b001100);
    is_ori  = (op == 6'b001101);
    is_xori = (op == 6'b001110);
    is_lui  = (op == 6'b001111);
    is_lw   = (op == 6'b100011);
    is_sw   = (op == 6'b101011);
    is_beq  = (op == 6'b000100);
    is_bne  = (op == 6'b000101);
    is_j    = (op == 6'b000010);
    is_jal  = (op == 6'b000011);

    is_shift = is_sll | is_srl | is_sra;
    r_alu    = is_add | is_sub | is_and | is_or | is_xor | is_shift;
    i_alu    = is_addi | is_andi | is_ori | is_xori | is_lui;
    decoded  = r_alu | is_jr | i_alu | is_lw | is_sw | is_beq | is_bne | is_j | is_jal;

    alu_code = ALU_ADD;
    if (is_sub)                alu_code = ALU_SUB;
    else if (is_and | is_andi) alu_code = ALU_AND;
    else if (is_or  | is_ori)  alu_code = ALU_OR;
    else if (is_xor | is_xori) alu_code = ALU_XOR;
    else if (is_lui)           alu_code = ALU_LUI;
    else if (is_sll)           alu_code = ALU_SLL;
    else if (is_srl)           alu_code = ALU_SRL;
    else if (is_sra)           alu_code = ALU_SRA;
  end

  // Next-state and control outputs from current state and decode
  always_comb begin
    next_state = state_q;
    mem_req_c  = 1'b0;
    wmem_c     = 1'b0;
    wir_c      = 1'b0;
    wpc_c      = 1'b0;
    wreg_c     = 1'b0;
    iord       = 1'b0;
    regrt      = 1'b0;
    m2reg      = 1'b0;
    jal        = 1'b0;
    shift      = 1'b0;
    sext       = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    aluc       = ALU_ADD;
    pcsource   = 2'b00;

    unique case (state_q)
      S_IF: begin
        mem_req_c = 1'b1;
        alusrcb   = 2'b01;
        if (mem_ready) begin
          wir_c      = 1'b1;
          wpc_c      = 1'b1;
          next_state = S_ID;
        end
      end
      S_ID: begin
        alusrcb = 2'b11;
        if (is_j) begin
          wpc_c      = 1'b1;
          pcsource   = 2'b11;
          next_state = S_IF;
        end else if (is_jal) begin
          wpc_c      = 1'b1;
          pcsource   = 2'b11;
          wreg_c     = 1'b1;
          jal        = 1'b1;
          next_state = S_IF;
        end else if (is_jr) begin
          wpc_c      = 1'b1;
          pcsource   = 2'b10;
          next_state = S_IF;
        end else if (!decoded) begin
          next_state = TRAP_ILLEGAL ? S_ERR : S_IF;
        end else begin
          next_state = S_EXE;
        end
      end
      S_EXE: begin
        next_state = S_IF;
        if (r_alu) begin
          alusrcb    = 2'b00;
          alusrca    = ~is_shift;
          shift      = is_shift;
          aluc       = alu_code;
          next_state = S_WB;
        end else if (i_alu) begin
          alusrcb    = 2'b10;
          sext       = is_addi;
          aluc       = alu_code;
          next_state = S_WB;
        end else if (is_lw | is_sw) begin
          alusrcb    = 2'b10;
          sext       = 1'b1;
          next_state = S_MEM;
        end else if (is_beq | is_bne) begin
          alusrcb = 2'b00;
          alusrca = 1'b1;
          aluc    = ALU_SUB;
          if ((is_beq & z) | (is_bne & ~z)) begin
            wpc_c    = 1'b1;
            pcsource = 2'b01;
          end
        end
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        iord      = 1'b1;
        wmem_c    = is_sw;
        if (mem_ready) next_state = is_lw ? S_WB : S_IF;
      end
      S_WB: begin
        wreg_c     = 1'b1;
        m2reg      = is_lw;
        regrt      = i_alu | is_lw;
        next_state = S_IF;
      end
      S_ERR: next_state = S_ERR;
      default: next_state = S_IF;
    endcase
  end

  // Strobes are forced low combinationally while reset is held, so an
  // access in flight is dropped in the same cycle reset asserts.
  assign mem_req = mem_req_c & resetn;
  assign wmem    = wmem_c    & resetn;
  assign wir     = wir_c     & resetn;
  assign wpc     = wpc_c     & resetn;
  assign wreg    = wreg_c    & resetn;
  assign state   = state_q;

  // State register, retired counter and sticky illegal flag
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IF;
      retired <= '0;
      illegal <= 1'b0;
    end else begin
      state_q <= next_state;
      if ((state_q != S_IF) && (next_state == S_IF))
        retired <= retired + CNT_W'(1);
      if (next_state == S_ERR)
        illegal <= 1'b1;
    end
  end

endmodule
